// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | Module   : alu_pkg                                                 |
// | Brief    : Shared opcodes, FSM state encoding and width default    |
// |            for the keypad ALU execution slice.                     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   localparam int c_ALU_WIDTH = 16;

   localparam logic [3:0] c_OP_ADD = 4'hA;
   localparam logic [3:0] c_OP_SUB = 4'hB;
   localparam logic [3:0] c_OP_MUL = 4'hC;
   localparam logic [3:0] c_OP_DIV = 4'hD;
   localparam logic [3:0] c_OP_POW = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// +--------------------------------------------------------------------+
// | Module   : alu_seq_muldiv                                          |
// | Brief    : Iterative shift-add multiplier / restoring divider,     |
// |            WIDTH cycles per operation; done/result are valid       |
// |            combinationally during the final iteration cycle.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = c_ALU_WIDTH
) (
   input  logic             IN_clk,
   input  logic             IN_reset,
   input  logic             start,
   input  logic             mode,      // 0 = multiply, 1 = divide
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic                 r_run;
   logic                 r_mode;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0]   r_acc;     // product, or remainder in the low bits
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_opa;     // multiplier, or dividend/quotient
   logic [WIDTH-1:0]     r_opb;     // divisor

   logic [2*WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH:0]       w_sub;
   logic                 w_neg;
   logic [WIDTH:0]       w_rem_nxt;
   logic [WIDTH-1:0]     w_quo_nxt;
   logic                 w_last;

   assign w_acc_nxt = r_acc + (r_opa[0] ? r_mcand : '0);
   assign w_rem_sh  = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
   assign w_neg     = (w_rem_sh < {1'b0, r_opb});
   assign w_sub     = w_rem_sh - {1'b0, r_opb};
   assign w_rem_nxt = w_neg ? w_rem_sh : w_sub;
   assign w_quo_nxt = {r_opa[WIDTH-2:0], ~w_neg};
   assign w_last    = (r_cnt == c_CNT_W'(WIDTH - 1));

   assign done   = r_run & w_last;
   assign result = r_mode ? w_quo_nxt : w_acc_nxt[WIDTH-1:0];
   assign ovf    = ~r_mode & (|w_acc_nxt[2*WIDTH-1:WIDTH]);

   always_ff @(posedge IN_clk or negedge IN_reset) begin
      if (!IN_reset) begin
         r_run   <= 1'b0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
      end else if (start) begin
         r_run   <= 1'b1;
         r_mode  <= mode;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= {{WIDTH{1'b0}}, a};
         r_opa   <= mode ? a : b;
         r_opb   <= b;
      end else if (r_run) begin
         r_cnt <= r_cnt + c_CNT_W'(1);
         if (w_last)
            r_run <= 1'b0;
         if (r_mode) begin
            r_acc <= {{(WIDTH-1){1'b0}}, w_rem_nxt};
            r_opa <= w_quo_nxt;
         end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_opa   <= r_opa >> 1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// +--------------------------------------------------------------------+
// | Module   : alu_exec                                                |
// | Brief    : Keypad ALU execution unit: edge-started add/sub/mul/    |
// |            div (and power when ALU_POW_EN is defined).             |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = c_ALU_WIDTH
) (
   input  logic             IN_clk,
   input  logic             IN_reset,
   input  logic [7:0]       IN_SRCH,
   input  logic [7:0]       IN_SRCL,
   input  logic [7:0]       IN_DSTH,
   input  logic [7:0]       IN_DSTL,
   input  logic [3:0]       IN_ALU_OP,
   input  logic             IN_finish,
   output logic [WIDTH-1:0] OUT_ans,
   output logic             OUT_valid,
   output logic             OUT_busy,
   output logic             OUT_ovf,
   output logic             OUT_err
);

   alu_state_t       r_state, w_state_nxt;
   logic             r_finish_q;
   logic             r_armed;
   logic [WIDTH-1:0] r_src, r_dst;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_res;
   logic             r_res_ovf, r_res_err;

   logic [WIDTH-1:0] w_src, w_dst;
   logic             w_start;
   logic             w_md_start, w_md_mode, w_md_done, w_md_ovf;
   logic [WIDTH-1:0] w_md_a, w_md_b, w_md_result;
   logic             w_calc_done;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf, w_err;

`ifdef ALU_POW_EN
   logic [WIDTH-1:0] r_pow_cnt;
   logic             r_pow_ovf;
   logic             w_pow_ovf_nxt, w_pow_last;
`endif

   assign w_src = WIDTH'({IN_SRCH, IN_SRCL});
   assign w_dst = WIDTH'({IN_DSTH, IN_DSTL});
   // r_armed masks the first cycle after reset so a level already high is not taken as an edge
   assign w_start = IN_finish & ~r_finish_q & r_armed;

   alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .IN_clk   (IN_clk),
      .IN_reset (IN_reset),
      .start    (w_md_start),
      .mode     (w_md_mode),
      .a        (w_md_a),
      .b        (w_md_b),
      .done     (w_md_done),
      .result   (w_md_result),
      .ovf      (w_md_ovf)
   );

   always_ff @(posedge IN_clk or negedge IN_reset) begin
      if (!IN_reset) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_CALC;
         ST_CALC: if (w_calc_done) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_md_start  = 1'b0;
      w_md_mode   = 1'b0;
      w_md_a      = w_src;
      w_md_b      = w_dst;
      w_calc_done = 1'b0;
      w_res       = '0;
      w_ovf       = 1'b0;
      w_err       = 1'b0;
`ifdef ALU_POW_EN
      w_pow_ovf_nxt = r_pow_ovf | w_md_ovf;
      w_pow_last    = w_pow_ovf_nxt | (r_pow_cnt == WIDTH'(1));
`endif
      case (r_state)
         ST_IDLE: begin
            w_md_mode = (IN_ALU_OP == c_OP_DIV);
            if (w_start) begin
               case (IN_ALU_OP)
                  c_OP_MUL: w_md_start = 1'b1;
                  c_OP_DIV: w_md_start = (w_dst != '0);
`ifdef ALU_POW_EN
                  c_OP_POW: begin
                     w_md_start = (w_dst != '0);
                     w_md_a     = WIDTH'(1);
                     w_md_b     = w_src;
                  end
`endif
                  default: w_md_start = 1'b0;
               endcase
            end
         end
         ST_CALC: begin
            case (r_op)
               c_OP_ADD: begin
                  w_calc_done    = 1'b1;
                  {w_ovf, w_res} = {1'b0, r_src} + {1'b0, r_dst};
               end
               c_OP_SUB: begin
                  w_calc_done = 1'b1;
                  w_res       = r_src - r_dst;
                  w_ovf       = (r_src < r_dst);
               end
               c_OP_MUL: begin
                  w_calc_done = w_md_done;
                  w_res       = w_md_result;
                  w_ovf       = w_md_ovf;
               end
               c_OP_DIV: begin
                  if (r_dst == '0) begin
                     w_calc_done = 1'b1;
                     w_res       = '1;
                     w_err       = 1'b1;
                  end else begin
                     w_calc_done = w_md_done;
                     w_res       = w_md_result;
                  end
               end
`ifdef ALU_POW_EN
               c_OP_POW: begin
                  if (r_dst == '0) begin
                     w_calc_done = 1'b1;
                     w_res       = WIDTH'(1);
                  end else begin
                     w_calc_done = w_md_done & w_pow_last;
                     w_res       = w_md_result;
                     w_ovf       = w_pow_ovf_nxt;
                     // chain the next multiply straight off the previous product
                     w_md_start  = w_md_done & ~w_pow_last;
                     w_md_a      = w_md_result;
                     w_md_b      = r_src;
                  end
               end
`endif
               default: begin
                  w_calc_done = 1'b1;
                  w_err       = 1'b1;
               end
            endcase
         end
         default: w_calc_done = 1'b0;
      endcase
   end

   always_ff @(posedge IN_clk or negedge IN_reset) begin
      if (!IN_reset) begin
         r_finish_q <= 1'b0;
         r_armed    <= 1'b0;
         r_src      <= '0;
         r_dst      <= '0;
         r_op       <= '0;
         r_res      <= '0;
         r_res_ovf  <= 1'b0;
         r_res_err  <= 1'b0;
         OUT_ans    <= '0;
         OUT_valid  <= 1'b0;
         OUT_busy   <= 1'b0;
         OUT_ovf    <= 1'b0;
         OUT_err    <= 1'b0;
`ifdef ALU_POW_EN
         r_pow_cnt  <= '0;
         r_pow_ovf  <= 1'b0;
`endif
      end else begin
         r_finish_q <= IN_finish;
         r_armed    <= 1'b1;
         OUT_valid  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_src    <= w_src;
                  r_dst    <= w_dst;
                  r_op     <= IN_ALU_OP;
                  OUT_busy <= 1'b1;
`ifdef ALU_POW_EN
                  r_pow_cnt <= w_dst;
                  r_pow_ovf <= 1'b0;
`endif
               end
            end
            ST_CALC: begin
               if (w_calc_done) begin
                  r_res     <= w_res;
                  r_res_ovf <= w_ovf;
                  r_res_err <= w_err;
               end
`ifdef ALU_POW_EN
               if (r_op == c_OP_POW && w_md_done) begin
                  r_pow_ovf <= w_pow_ovf_nxt;
                  r_pow_cnt <= r_pow_cnt - WIDTH'(1);
               end
`endif
            end
            ST_DONE: begin
               OUT_ans   <= r_res;
               OUT_ovf   <= r_res_ovf;
               OUT_err   <= r_res_err;
               OUT_valid <= 1'b1;
               OUT_busy  <= 1'b0;
            end
            default: OUT_valid <= 1'b0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// +--------------------------------------------------------------------+
// | Module   : tb_alu_exec                                             |
// | Brief    : Directed self-checking bench for alu_exec (power        |
// |            vectors active when ALU_POW_EN is defined).             |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec;

   logic        IN_clk = 1'b0;
   logic        IN_reset;
   logic [7:0]  IN_SRCH, IN_SRCL, IN_DSTH, IN_DSTL;
   logic [3:0]  IN_ALU_OP;
   logic        IN_finish;
   logic [15:0] OUT_ans;
   logic        OUT_valid, OUT_busy, OUT_ovf, OUT_err;

   int n_tests = 0;
   int n_fail  = 0;

   alu_exec #(.WIDTH(16)) dut (
      .IN_clk    (IN_clk),
      .IN_reset  (IN_reset),
      .IN_SRCH   (IN_SRCH),
      .IN_SRCL   (IN_SRCL),
      .IN_DSTH   (IN_DSTH),
      .IN_DSTL   (IN_DSTL),
      .IN_ALU_OP (IN_ALU_OP),
      .IN_finish (IN_finish),
      .OUT_ans   (OUT_ans),
      .OUT_valid (OUT_valid),
      .OUT_busy  (OUT_busy),
      .OUT_ovf   (OUT_ovf),
      .OUT_err   (OUT_err)
   );

   always #5 IN_clk = ~IN_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge IN_clk);
      #1;
   endtask

   task automatic set_ops(input logic [15:0] src, input logic [15:0] dst, input logic [3:0] op);
      {IN_SRCH, IN_SRCL} = src;
      {IN_DSTH, IN_DSTL} = dst;
      IN_ALU_OP          = op;
   endtask

   task automatic run_op(input string tag, input logic [15:0] src, input logic [15:0] dst,
                         input logic [3:0] op, input int exp_lat, input logic [15:0] exp_ans,
                         input logic exp_ovf, input logic exp_err);
      int lat;
      set_ops(src, dst, op);
      IN_finish = 1'b1;
      tick();
      check({tag, "_busy"}, 32'(OUT_busy), 32'd1);
      lat = 0;
      while (!OUT_valid && lat < 400) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_ans"}, 32'(OUT_ans), 32'(exp_ans));
      check({tag, "_ovf"}, 32'(OUT_ovf), 32'(exp_ovf));
      check({tag, "_err"}, 32'(OUT_err), 32'(exp_err));
      IN_finish = 1'b0;
      tick();
      check({tag, "_pulse"}, 32'(OUT_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nvalid;
      logic [15:0] seen_ans;

      // reset with IN_finish already high: must not start on release
      IN_reset  = 1'b0;
      IN_finish = 1'b1;
      set_ops(16'd12, 16'd34, 4'hA);
      tick();
      tick();
      check("rst_ans",   32'(OUT_ans),   32'd0);
      check("rst_valid", 32'(OUT_valid), 32'd0);
      check("rst_busy",  32'(OUT_busy),  32'd0);
      check("rst_ovf",   32'(OUT_ovf),   32'd0);
      check("rst_err",   32'(OUT_err),   32'd0);
      IN_reset = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (OUT_busy || OUT_valid) nvalid++;
      end
      check("rel_high_nostart", 32'(nvalid), 32'd0);
      IN_finish = 1'b0;
      tick();

      run_op("add",    16'd12,   16'd34,  4'hA, 2,  16'd46,   1'b0, 1'b0);
      run_op("addc",   16'hFFFF, 16'd1,   4'hA, 2,  16'h0000, 1'b1, 1'b0);
      run_op("sub",    16'd5,    16'd9,   4'hB, 2,  16'hFFFC, 1'b1, 1'b0);
      run_op("sub_ok", 16'd9,    16'd5,   4'hB, 2,  16'd4,    1'b0, 1'b0);
      run_op("mul",    16'd300,  16'd200, 4'hC, 17, 16'hEA60, 1'b0, 1'b0);
      run_op("mulov",  16'd300,  16'd300, 4'hC, 17, 16'h5F90, 1'b1, 1'b0);
      run_op("div",    16'd999,  16'd7,   4'hD, 17, 16'd142,  1'b0, 1'b0);
      run_op("div0",   16'd999,  16'd0,   4'hD, 2,  16'hFFFF, 1'b0, 1'b1);
      repeat (3) tick();
      check("err_held", 32'(OUT_err), 32'd1);
      run_op("inv3",   16'd1,    16'd2,   4'h3, 2,  16'h0000, 1'b0, 1'b1);
      run_op("invF",   16'd1,    16'd2,   4'hF, 2,  16'h0000, 1'b0, 1'b1);
`ifdef ALU_POW_EN
      run_op("pow34",  16'd3,    16'd4,   4'hE, 65,  16'd81,  1'b0, 1'b0);
      run_op("pow216", 16'd2,    16'd16,  4'hE, 257, 16'd0,   1'b1, 1'b0);
      run_op("pow50",  16'd5,    16'd0,   4'hE, 2,   16'd1,   1'b0, 1'b0);
`else
      run_op("powoff", 16'd3,    16'd4,   4'hE, 2,  16'h0000, 1'b0, 1'b1);
`endif

      // second rising edge during a multiply with changed operands
      set_ops(16'd7, 16'd6, 4'hC);
      IN_finish = 1'b1;
      tick();
      IN_finish = 1'b0;
      repeat (3) tick();
      set_ops(16'd9, 16'd9, 4'hA);
      IN_finish = 1'b1;
      nvalid   = 0;
      seen_ans = '0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (OUT_valid) begin
            nvalid++;
            seen_ans = OUT_ans;
         end
      end
      check("busy_nvalid", 32'(nvalid), 32'd1);
      check("busy_ans", 32'(seen_ans), 32'd42);
      IN_finish = 1'b0;
      tick();

      // a rising edge that lands in the DONE cycle is dropped
      set_ops(16'd1, 16'd1, 4'hA);
      IN_finish = 1'b1;
      tick();
      IN_finish = 1'b0;
      tick();
      IN_finish = 1'b1;
      tick();
      check("done_valid", 32'(OUT_valid), 32'd1);
      check("done_ans", 32'(OUT_ans), 32'd2);
      nvalid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (OUT_busy || OUT_valid) nvalid++;
      end
      check("done_edge_ignored", 32'(nvalid), 32'd0);
      IN_finish = 1'b0;
      tick();

      // reset in cycle 8 of a divide aborts it
      set_ops(16'd1000, 16'd3, 4'hD);
      IN_finish = 1'b1;
      tick();
      IN_finish = 1'b0;
      repeat (7) tick();
      IN_reset = 1'b0;
      #1;
      check("abort_ans",   32'(OUT_ans),   32'd0);
      check("abort_busy",  32'(OUT_busy),  32'd0);
      check("abort_valid", 32'(OUT_valid), 32'd0);
      check("abort_err",   32'(OUT_err),   32'd0);
      tick();
      tick();
      IN_reset = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (OUT_valid || OUT_busy) nvalid++;
      end
      check("abort_novalid", 32'(nvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have port IN_clk, input, 1: clock; all state changes on its rising edge.
REQ-003 SHALL have port IN_reset, input, 1: reset; asynchronous, active-low.
REQ-004 SHALL have ports IN_SRCH/IN_SRCL, input, 8 each: first operand, SRC = {IN_SRCH, IN_SRCL}.
REQ-005 SHALL have ports IN_DSTH/IN_DSTL, input, 8 each: second operand, DST = {IN_DSTH, IN_DSTL}.
REQ-006 SHALL have port IN_ALU_OP, input, 4: opcode; A=add, B=sub, C=mul, D=div, E=power.
REQ-007 SHALL have port IN_finish, input, 1: request level from keypad sequencer; a 0->1 edge starts an operation.
REQ-008 SHALL have port OUT_ans, output, WIDTH: result, held until the next completion.
REQ-009 SHALL have port OUT_valid, output, 1: one-cycle pulse when OUT_ans updates.
REQ-010 SHALL have port OUT_busy, output, 1: high from capture to completion.
REQ-011 SHALL have port OUT_ovf, output, 1: result truncated or sub borrow; valid with OUT_valid, held.
REQ-012 SHALL have port OUT_err, output, 1: divide by zero or invalid opcode; valid with OUT_valid, held.

Function
REQ-013 SHALL register IN_finish each cycle; start = IN_finish & ~finish_q.
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-015 IDLE: on start, SHALL capture SRC, DST and opcode, raise OUT_busy and enter CALC in the same edge.
REQ-016 Start while OUT_busy is high SHALL be ignored; the operands in flight SHALL NOT change.
REQ-017 Add/sub SHALL take 1 CALC cycle; sub with SRC<DST wraps modulo 2^WIDTH and sets OUT_ovf.
REQ-018 Mul SHALL be shift-add over WIDTH CALC cycles; low WIDTH bits returned; OUT_ovf if any upper product bit is set.
REQ-019 Div SHALL be restoring, WIDTH CALC cycles, returning the quotient (remainder discarded).
REQ-020 Div with DST=0 SHALL take 1 CALC cycle, giving OUT_ans=all-ones and OUT_err=1.
REQ-021 Power SHALL compute SRC^DST by DST sequential multiplies, each WIDTH cycles; DST=0 gives 1 after 1 cycle.
REQ-022 Power: OUT_ovf is sticky across iterations; iteration SHALL stop early once OUT_ovf sets.
REQ-023 Opcodes 0-9 and F SHALL give OUT_ans=0 and OUT_err=1 after 1 CALC cycle.
REQ-024 DONE: for one cycle, SHALL load OUT_ans, OUT_ovf and OUT_err, pulse OUT_valid, drop OUT_busy, return to IDLE.
REQ-025 Start-to-valid latency: add/sub/invalid/div0 = 2 cycles; mul/div = WIDTH+1 cycles.
REQ-026 A start arriving in the DONE cycle SHALL be ignored; an edge seen in IDLE is accepted, giving back-to-back throughput of 1 op per latency+1 cycles.

Reset
REQ-027 While IN_reset=0: state=IDLE, finish_q=0, OUT_ans=0, OUT_valid=0, OUT_busy=0, OUT_ovf=0, OUT_err=0.
REQ-028 Reset mid-CALC SHALL abort the operation with no OUT_valid pulse.
REQ-029 After reset release, an IN_finish already high SHALL NOT start an operation until it falls and rises again.

Configuration
REQ-030 With macro ALU_POW_EN defined, opcode E SHALL compute power per REQ-021/022.
REQ-031 Without ALU_POW_EN, opcode E SHALL be handled as invalid per REQ-023, and no power iteration logic SHALL be present.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode constants (A-E), the FSM state enum and the WIDTH default.
REQ-033 Iterative mul/div datapath SHALL be sub-module alu_seq_muldiv (start, mode, a, b -> done, result, ovf), shared by mul, div and power.
REQ-034 FSM, edge detection and flag logic SHALL reside in alu_exec.

Verification
REQ-035 SRC=12, DST=34, op A, rising edge on IN_finish -> OUT_valid 2 cycles later, OUT_ans=46, ovf=0, err=0.
REQ-036 SRC=5, DST=9, op B -> OUT_ans=0xFFFC, OUT_ovf=1; then SRC=300, DST=200, op C -> OUT_ans=0xEA60 at 17 cycles, OUT_ovf=0.
REQ-037 SRC=999, DST=7, op D -> OUT_ans=142 at 17 cycles; repeat with DST=0 -> OUT_ans=0xFFFF, OUT_err=1 at 2 cycles.
REQ-038 ALU_POW_EN defined: 3^4 gives 81, 2^16 gives ovf=1; undefined: op E gives OUT_ans=0, err=1.
REQ-039 Second IN_finish edge during a mul -> ignored, exactly one OUT_valid; assert IN_reset at cycle 8 of a div -> all outputs 0, no OUT_valid.
